r88_alu_seq: RTL and testbench

- Control-side initiator for the Rocket88 ALU. It accepts one ALU command per handshake from the instruction decoder and drives the ALU's strobes (aluOp, rightSel, loadResult, aluResult, carry controls) over a fixed multi-cycle sequence.
- Captures carry/zero/negative into the flag register and issues register-file write strobes.
- Sits between the decoder and r88_alu; ready/start toward the decoder, ALU control lines toward the ALU.

---
 rtl/r88_alu_seq_if.sv | 37 +++
 rtl/r88_alu_seq.sv | 90 +++++++++
 tb/tb_r88_alu_seq.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/r88_alu_seq_if.sv
// r88_alu_seq_if: decoder command handshake plus ALU control/observation bundle for r88_alu_seq.
// flagP is present only when R88_ALU_SEQ_PARITY_EN is defined.
interface r88_alu_seq_if;
  logic       start, ready;
  logic [2:0] cmdOp;
  logic       cmdImm, cmdUseCarry, cmdDec, cmdWide, cmdInv;
  logic [2:0] aluOp;
  logic       rightSel, carryIn, carryInEn, decMode, regLeft16, invOut;
  logic       loadResult, aluResult, immOe;
  logic       carryOut;
  logic [7:0] aluData, highOut;
  logic       resultWe, highWe, done;
  logic       flagC, flagZ, flagN;
`ifdef R88_ALU_SEQ_PARITY_EN
  logic       flagP;
`endif
  modport master (
    output start, cmdOp, cmdImm, cmdUseCarry, cmdDec, cmdWide, cmdInv,
    output carryOut, aluData, highOut,
    input  ready, aluOp, rightSel, carryIn, carryInEn, decMode, regLeft16, invOut,
    input  loadResult, aluResult, immOe, resultWe, highWe, done,
    input  flagC, flagZ, flagN
`ifdef R88_ALU_SEQ_PARITY_EN
    , input flagP
`endif
  );
  modport slave (
    input  start, cmdOp, cmdImm, cmdUseCarry, cmdDec, cmdWide, cmdInv,
    input  carryOut, aluData, highOut,
    output ready, aluOp, rightSel, carryIn, carryInEn, decMode, regLeft16, invOut,
    output loadResult, aluResult, immOe, resultWe, highWe, done,
    output flagC, flagZ, flagN
`ifdef R88_ALU_SEQ_PARITY_EN
    , output flagP
`endif
  );
endinterface

// File: rtl/r88_alu_seq.sv
// r88_alu_seq: Rocket88 ALU command sequencer driving ALU strobes, flag capture and result writes.
// Optional R88_ALU_SEQ_PARITY_EN adds a parity flag register (flagP).
module r88_alu_seq (
  input logic          sysClock,
  input logic          sysResetN,
  r88_alu_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, OPER, EXEC, LATCH, RESULT, HIGH} state_t;
  state_t     state, next;
  logic [2:0] op_q;
  logic       imm_q, cen_q, dec_q, wide_q, inv_q;
  logic       flag_c, flag_z, flag_n;
  logic       arith, carry_op, carry_cap, busy, accept;
  assign arith     = bus.cmdOp inside {3'd3, 3'd4};
  assign carry_op  = bus.cmdOp inside {[3'd1:3'd4]};
  assign carry_cap = op_q inside {[3'd1:3'd4]};
  assign accept    = state == IDLE && bus.start;
  always_ff @(posedge sysClock or negedge sysResetN)
    if (!sysResetN) state <= IDLE;
    else state <= next;
  always_comb
    case (state)
      IDLE:    next = bus.start ? (bus.cmdImm ? OPER : EXEC) : IDLE;
      OPER:    next = EXEC;
      EXEC:    next = LATCH;
      LATCH:   next = RESULT;
      RESULT:  next = wide_q ? HIGH : IDLE;
      default: next = IDLE;
    endcase
  // Command fields are sanitised once at capture so the ALU never sees illegal mode combinations.
  always_ff @(posedge sysClock or negedge sysResetN)
    if (!sysResetN) begin
      op_q   <= '0;
      imm_q  <= 1'b0;
      cen_q  <= 1'b0;
      dec_q  <= 1'b0;
      wide_q <= 1'b0;
      inv_q  <= 1'b0;
    end else if (accept) begin
      op_q   <= bus.cmdOp;
      imm_q  <= bus.cmdImm;
      cen_q  <= bus.cmdUseCarry & carry_op;
      dec_q  <= bus.cmdDec & arith;
      wide_q <= bus.cmdWide & arith;
      inv_q  <= bus.cmdInv;
    end
  always_ff @(posedge sysClock or negedge sysResetN)
    if (!sysResetN) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (state == RESULT) begin
      flag_n <= bus.aluData[7];
      flag_z <= bus.aluData == 8'h00;
      if (carry_cap) flag_c <= bus.carryOut;
    end else if (state == HIGH) begin
      flag_n <= bus.highOut[7];
      flag_z <= flag_z & (bus.highOut == 8'h00);
      flag_c <= bus.carryOut;
    end
`ifdef R88_ALU_SEQ_PARITY_EN
  logic flag_p;
  always_ff @(posedge sysClock or negedge sysResetN)
    if (!sysResetN) flag_p <= 1'b0;
    else if (state == RESULT) flag_p <= ~^bus.aluData;
    else if (state == HIGH) flag_p <= ~^bus.highOut;
  assign bus.flagP = flag_p;
`endif
  // immOe is confined to OPER/EXEC and aluResult to RESULT/HIGH, so intD never has two drivers.
  always_comb begin
    busy           = state != IDLE;
    bus.ready      = !busy;
    bus.aluOp      = busy ? op_q : 3'd0;
    bus.rightSel   = busy & imm_q;
    bus.carryInEn  = busy & cen_q;
    bus.decMode    = busy & dec_q;
    bus.regLeft16  = busy & wide_q;
    bus.invOut     = busy & inv_q;
    bus.carryIn    = flag_c;
    bus.immOe      = state == OPER || (state == EXEC && imm_q);
    bus.loadResult = state == LATCH;
    bus.aluResult  = state == RESULT || state == HIGH;
    bus.resultWe   = state == RESULT;
    bus.highWe     = state == HIGH;
    bus.done       = (state == RESULT && !wide_q) || state == HIGH;
    bus.flagC      = flag_c;
    bus.flagZ      = flag_z;
    bus.flagN      = flag_n;
  end
endmodule

// File: tb/tb_r88_alu_seq.sv
// tb_r88_alu_seq: directed self-checking bench for r88_alu_seq; cycle k counts edges after the start cycle.
module tb_r88_alu_seq;
  logic sysClock = 1'b0;
  logic sysResetN = 1'b0;
  int checks = 0;
  int errors = 0;
  int we_count = 0;
  int overlap = 0;
  always #5 sysClock = ~sysClock;
  r88_alu_seq_if bus ();
  r88_alu_seq dut (.sysClock(sysClock), .sysResetN(sysResetN), .bus(bus));
  always @(negedge sysClock) begin
    if (bus.resultWe === 1'b1) we_count++;
    if (bus.immOe === 1'b1 && bus.aluResult === 1'b1) overlap++;
  end

  task automatic issue(input logic [2:0] op, input logic imm, uc, dec, wide, inv);
    @(negedge sysClock);
    bus.cmdOp = op; bus.cmdImm = imm; bus.cmdUseCarry = uc;
    bus.cmdDec = dec; bus.cmdWide = wide; bus.cmdInv = inv;
    bus.start = 1'b1;
    @(negedge sysClock);
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({bus.ready, bus.immOe, bus.aluResult, bus.loadResult, bus.resultWe, bus.highWe, bus.done} !== 7'b1000000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 1000000", {bus.ready, bus.immOe, bus.aluResult, bus.loadResult, bus.resultWe, bus.highWe, bus.done});
    end
    checks++;
    if ({bus.flagN, bus.flagZ, bus.flagC, bus.aluOp, bus.carryInEn, bus.decMode, bus.regLeft16} !== 9'b0) begin
      errors++; $display("FAIL reset_flags_ctrl: got %b expected 000000000", {bus.flagN, bus.flagZ, bus.flagC, bus.aluOp, bus.carryInEn, bus.decMode, bus.regLeft16});
    end
    @(negedge sysClock);
    sysResetN = 1'b1;
  endtask

  task automatic test_add_carry;
    bus.aluData = 8'h01; bus.carryOut = 1'b1;
    issue(3'd3, 0, 0, 0, 0, 0);
    repeat (3) @(negedge sysClock);
    checks++;
    if (bus.flagC !== 1'b1) begin errors++; $display("FAIL add_preset_c: got %b expected 1", bus.flagC); end
    bus.aluData = 8'h00; bus.carryOut = 1'b1;
    issue(3'd3, 0, 1, 0, 0, 0);
    checks++;
    if ({bus.carryIn, bus.carryInEn, bus.rightSel, bus.aluOp} !== 6'b110011) begin
      errors++; $display("FAIL add_exec: got %b expected 110011", {bus.carryIn, bus.carryInEn, bus.rightSel, bus.aluOp});
    end
    @(negedge sysClock);
    checks++;
    if ({bus.resultWe, bus.done, bus.loadResult} !== 3'b001) begin
      errors++; $display("FAIL add_latch: got %b expected 001", {bus.resultWe, bus.done, bus.loadResult});
    end
    @(negedge sysClock);
    checks++;
    if ({bus.resultWe, bus.done, bus.aluResult} !== 3'b111) begin
      errors++; $display("FAIL add_result: got %b expected 111", {bus.resultWe, bus.done, bus.aluResult});
    end
    @(negedge sysClock);
    checks++;
    if ({bus.flagZ, bus.flagC, bus.flagN, bus.ready} !== 4'b1101) begin
      errors++; $display("FAIL add_flags: got %b expected 1101", {bus.flagZ, bus.flagC, bus.flagN, bus.ready});
    end
  endtask

  task automatic test_xor_imm;
    bus.aluData = 8'h80; bus.carryOut = 1'b0;
    issue(3'd7, 1, 0, 0, 0, 0);
    checks++;
    if ({bus.immOe, bus.rightSel, bus.carryInEn, bus.aluOp} !== 6'b110111) begin
      errors++; $display("FAIL xor_oper: got %b expected 110111", {bus.immOe, bus.rightSel, bus.carryInEn, bus.aluOp});
    end
    @(negedge sysClock);
    checks++;
    if ({bus.immOe, bus.loadResult, bus.done} !== 3'b100) begin
      errors++; $display("FAIL xor_exec: got %b expected 100", {bus.immOe, bus.loadResult, bus.done});
    end
    @(negedge sysClock);
    checks++;
    if ({bus.immOe, bus.loadResult, bus.done} !== 3'b010) begin
      errors++; $display("FAIL xor_latch: got %b expected 010", {bus.immOe, bus.loadResult, bus.done});
    end
    @(negedge sysClock);
    checks++;
    if ({bus.done, bus.aluResult, bus.immOe, bus.resultWe, bus.rightSel} !== 5'b11011) begin
      errors++; $display("FAIL xor_result: got %b expected 11011", {bus.done, bus.aluResult, bus.immOe, bus.resultWe, bus.rightSel});
    end
    @(negedge sysClock);
    checks++;
    if ({bus.flagN, bus.flagZ, bus.flagC} !== 3'b101) begin
      errors++; $display("FAIL xor_flags: got %b expected 101", {bus.flagN, bus.flagZ, bus.flagC});
    end
  endtask

  task automatic test_wide_add;
    bus.aluData = 8'h00; bus.highOut = 8'h12; bus.carryOut = 1'b0;
    issue(3'd3, 0, 0, 1, 1, 0);
    checks++;
    if ({bus.decMode, bus.regLeft16} !== 2'b11) begin
      errors++; $display("FAIL wide_modes: got %b expected 11", {bus.decMode, bus.regLeft16});
    end
    repeat (2) @(negedge sysClock);
    checks++;
    if ({bus.resultWe, bus.highWe, bus.done} !== 3'b100) begin
      errors++; $display("FAIL wide_result: got %b expected 100", {bus.resultWe, bus.highWe, bus.done});
    end
    @(negedge sysClock);
    checks++;
    if ({bus.resultWe, bus.highWe, bus.done, bus.aluResult} !== 4'b0111) begin
      errors++; $display("FAIL wide_high: got %b expected 0111", {bus.resultWe, bus.highWe, bus.done, bus.aluResult});
    end
    @(negedge sysClock);
    checks++;
    if ({bus.flagN, bus.flagZ, bus.flagC, bus.ready, bus.done, bus.decMode, bus.regLeft16} !== 7'b0001000) begin
      errors++; $display("FAIL wide_flags_idle: got %b expected 0001000", {bus.flagN, bus.flagZ, bus.flagC, bus.ready, bus.done, bus.decMode, bus.regLeft16});
    end
  endtask

  task automatic test_or_sanitise;
    bus.aluData = 8'h0F; bus.carryOut = 1'b1;
    issue(3'd5, 0, 1, 1, 1, 1);
    checks++;
    if ({bus.regLeft16, bus.decMode, bus.carryInEn, bus.invOut, bus.aluOp} !== 7'b0001101) begin
      errors++; $display("FAIL or_sanitise: got %b expected 0001101", {bus.regLeft16, bus.decMode, bus.carryInEn, bus.invOut, bus.aluOp});
    end
    repeat (2) @(negedge sysClock);
    checks++;
    if ({bus.done, bus.resultWe} !== 2'b11) begin
      errors++; $display("FAIL or_done: got %b expected 11", {bus.done, bus.resultWe});
    end
    @(negedge sysClock);
    checks++;
    if ({bus.highWe, bus.done, bus.ready, bus.flagN, bus.flagZ, bus.flagC} !== 6'b001000) begin
      errors++; $display("FAIL or_no_high: got %b expected 001000", {bus.highWe, bus.done, bus.ready, bus.flagN, bus.flagZ, bus.flagC});
    end
  endtask

  task automatic test_reset_mid;
    int we0;
    bus.aluData = 8'h90; bus.carryOut = 1'b1;
    issue(3'd3, 0, 0, 0, 0, 0);
    repeat (3) @(negedge sysClock);
    checks++;
    if ({bus.flagN, bus.flagC} !== 2'b11) begin
      errors++; $display("FAIL rst_preset: got %b expected 11", {bus.flagN, bus.flagC});
    end
    issue(3'd3, 0, 1, 0, 0, 0);
    @(negedge sysClock);
    checks++;
    if (bus.loadResult !== 1'b1) begin errors++; $display("FAIL rst_in_latch: got %b expected 1", bus.loadResult); end
    we0 = we_count;
    sysResetN = 1'b0;
    #1;
    checks++;
    if ({bus.ready, bus.loadResult, bus.aluResult, bus.resultWe, bus.done, bus.immOe, bus.aluOp, bus.carryInEn} !== 10'b1000000000) begin
      errors++; $display("FAIL rst_strobes: got %b expected 1000000000", {bus.ready, bus.loadResult, bus.aluResult, bus.resultWe, bus.done, bus.immOe, bus.aluOp, bus.carryInEn});
    end
    checks++;
    if ({bus.flagN, bus.flagZ, bus.flagC} !== 3'b000) begin
      errors++; $display("FAIL rst_flags: got %b expected 000", {bus.flagN, bus.flagZ, bus.flagC});
    end
    repeat (2) @(negedge sysClock);
    sysResetN = 1'b1;
    repeat (4) @(negedge sysClock);
    checks++;
    if (we_count !== we0) begin errors++; $display("FAIL rst_no_write: got %0d expected %0d", we_count, we0); end
  endtask

  task automatic test_back_to_back;
    int acc = 0;
    int dn = 0;
    @(negedge sysClock);
    bus.cmdOp = 3'd7; bus.cmdImm = 1'b1; bus.cmdUseCarry = 1'b0;
    bus.cmdDec = 1'b0; bus.cmdWide = 1'b0; bus.cmdInv = 1'b0;
    bus.start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.ready === 1'b1) acc++;
      if (bus.done === 1'b1) dn++;
      @(negedge sysClock);
    end
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done === 1'b1) dn++;
      @(negedge sysClock);
    end
    checks++;
    if (acc !== 4) begin errors++; $display("FAIL b2b_accepts: got %0d expected 4", acc); end
    checks++;
    if (dn !== 4) begin errors++; $display("FAIL b2b_dones: got %0d expected 4", dn); end
    checks++;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: got %b expected 1", bus.ready); end
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL intd_overlap: got %0d expected 0", overlap); end
  endtask

  initial begin
    bus.start = 1'b0; bus.cmdOp = 3'd0; bus.cmdImm = 1'b0; bus.cmdUseCarry = 1'b0;
    bus.cmdDec = 1'b0; bus.cmdWide = 1'b0; bus.cmdInv = 1'b0;
    bus.carryOut = 1'b0; bus.aluData = 8'h00; bus.highOut = 8'h00;
    test_reset;
    test_add_carry;
    test_xor_imm;
    test_wide_add;
    test_or_sanitise;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
